// File: rtl/note_sequencer.sv
// Note-list playback sequencer: fetches (note, duration) pairs from an external
// note memory and drives note_out for the requested number of duration ticks.
module note_sequencer #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int DEPTH     = 100,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  output logic       mem_rd,
  output logic [6:0] mem_addr,
  input  logic [4:0] mem_note,
  input  logic [3:0] mem_dur,
  output logic [4:0] note_out,
  output logic       busy,
  output logic       done,
  output logic [6:0] cur_idx
);

  // state | meaning
  // IDLE  | silent, waiting for start
  // FETCH | read strobe to note memory
  // WAIT  | memory data valid; decode end marker or load note
  // PLAY  | note (or rest) sounding, counting duration ticks
  // GAP   | silence between notes
  // END   | song finished; loop back or pulse done

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [6:0]    ADDR_LAST = 7'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_END
  } state_t;

  state_t        state;
  logic          mem_rd_q;
  logic [4:0]    note_q;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    remaining;
  logic [GW-1:0] gap_cnt;

  // Read strobe is gated so a frozen FETCH never issues a stray read.
  assign mem_rd   = mem_rd_q & en;
  assign note_out = pause ? 5'd0 : note_q;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mem_rd_q  <= 1'b0;
      mem_addr  <= '0;
      note_q    <= '0;
      cur_idx   <= '0;
      done      <= 1'b0;
      tick_cnt  <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
    end else if (en) begin
      mem_rd_q <= 1'b0;
      done     <= 1'b0;
      if (stop) begin
        state     <= S_IDLE;
        note_q    <= '0;
        mem_addr  <= '0;
        tick_cnt  <= '0;
        remaining <= '0;
        gap_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            note_q <= '0;
            if (start) begin
              mem_addr <= '0;
              mem_rd_q <= 1'b1;
              state    <= S_FETCH;
            end
          end
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            if (mem_note == '0 && mem_dur == '0) begin
              state <= S_END;
            end else begin
              note_q    <= mem_note;
              cur_idx   <= mem_addr;
              remaining <= (mem_dur == '0) ? 4'd1 : mem_dur;
              tick_cnt  <= '0;
              state     <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (!pause) begin
              if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (remaining <= 4'd1) begin
                  remaining <= '0;
                  note_q    <= '0;
                  if (GAP_TICKS == 0) begin
                    if (mem_addr < ADDR_LAST) begin
                      mem_addr <= mem_addr + 7'd1;
                      mem_rd_q <= 1'b1;
                      state    <= S_FETCH;
                    end else begin
                      state <= S_END;
                    end
                  end else begin
                    gap_cnt <= '0;
                    state   <= S_GAP;
                  end
                end else begin
                  remaining <= remaining - 4'd1;
                end
              end else begin
                tick_cnt <= tick_cnt + TW'(1);
              end
            end
          end
          S_GAP: begin
            if (!pause) begin
              if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (gap_cnt == GAP_LAST) begin
                  if (mem_addr < ADDR_LAST) begin
                    mem_addr <= mem_addr + 7'd1;
                    mem_rd_q <= 1'b1;
                    state    <= S_FETCH;
                  end else begin
                    state <= S_END;
                  end
                end else begin
                  gap_cnt <= gap_cnt + GW'(1);
                end
              end else begin
                tick_cnt <= tick_cnt + TW'(1);
              end
            end
          end
          S_END: begin
            if (loop_en) begin
              mem_addr <= '0;
              mem_rd_q <= 1'b1;
              state    <= S_FETCH;
            end else begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, GAP_TICKS=1, DEPTH=100.
// Sample index k=0 is the FETCH cycle right after the edge that accepted start.
module tb_note_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int DEPTH     = 100;
  localparam int GAP_TICKS = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop_en = 1'b0;
  logic       mem_rd;
  logic [6:0] mem_addr;
  logic [4:0] mem_note = '0;
  logic [3:0] mem_dur = '0;
  logic [4:0] note_out;
  logic       busy;
  logic       done;
  logic [6:0] cur_idx;

  logic [4:0] rom_note [0:127];
  logic [3:0] rom_dur  [0:127];

  int vectors = 0;
  int errors  = 0;

  note_sequencer #(
    .TICK_DIV(TICK_DIV),
    .DEPTH(DEPTH),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .start(start),
    .stop(stop),
    .pause(pause),
    .loop_en(loop_en),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_note(mem_note),
    .mem_dur(mem_dur),
    .note_out(note_out),
    .busy(busy),
    .done(done),
    .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  // Synchronous note memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_note <= rom_note[mem_addr];
      mem_dur  <= rom_dur[mem_addr];
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 128; i++) begin
      rom_note[i] = '0;
      rom_dur[i]  = '0;
    end
  endtask

  task automatic test_reset;
    clear_rom();
    start = 1'b1;
    repeat (3) cyc();
    vectors++; if (note_out !== 5'd0) begin errors++; $display("FAIL reset_note got %0d want 0", note_out); end
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %0b want 0", mem_rd); end
    vectors++; if (mem_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    vectors++; if (cur_idx !== 7'd0) begin errors++; $display("FAIL reset_cur_idx got %0d want 0", cur_idx); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    start = 1'b0;
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_basic;
    logic [4:0] exp_note;
    clear_rom();
    rom_note[0] = 5'd3; rom_dur[0] = 4'd2;
    rom_note[1] = 5'd5; rom_dur[1] = 4'd1;
    start = 1'b1;
    for (int k = 0; k <= 28; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
      exp_note = (k >= 2 && k <= 9) ? 5'd3 : (k >= 16 && k <= 19) ? 5'd5 : 5'd0;
      vectors++; if (note_out !== exp_note) begin errors++; $display("FAIL basic_note k=%0d got %0d want %0d", k, note_out, exp_note); end
      vectors++; if (busy !== (k <= 26)) begin errors++; $display("FAIL basic_busy k=%0d got %0b want %0b", k, busy, (k <= 26)); end
      vectors++; if (done !== (k == 27)) begin errors++; $display("FAIL basic_done k=%0d got %0b want %0b", k, done, (k == 27)); end
      if (k == 0 || k == 14) begin
        vectors++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL basic_rd k=%0d got %0b want 1", k, mem_rd); end
        vectors++; if (mem_addr !== ((k == 0) ? 7'd0 : 7'd1)) begin errors++; $display("FAIL basic_addr k=%0d got %0d", k, mem_addr); end
      end
      if (k == 1) begin
        vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL basic_rd_one_cycle got %0b want 0", mem_rd); end
      end
      if (k == 16) begin
        vectors++; if (cur_idx !== 7'd1) begin errors++; $display("FAIL basic_cur_idx got %0d want 1", cur_idx); end
      end
    end
  endtask

  task automatic test_rest;
    logic [4:0] exp_note;
    clear_rom();
    rom_note[0] = 5'd0; rom_dur[0] = 4'd3;
    rom_note[1] = 5'd7; rom_dur[1] = 4'd0;
    start = 1'b1;
    for (int k = 0; k <= 31; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
      exp_note = (k >= 20 && k <= 23) ? 5'd7 : 5'd0;
      vectors++; if (note_out !== exp_note) begin errors++; $display("FAIL rest_note k=%0d got %0d want %0d", k, note_out, exp_note); end
      vectors++; if (busy !== (k <= 30)) begin errors++; $display("FAIL rest_busy k=%0d got %0b want %0b", k, busy, (k <= 30)); end
      vectors++; if (done !== (k == 31)) begin errors++; $display("FAIL rest_done k=%0d got %0b want %0b", k, done, (k == 31)); end
      if (k == 2) begin
        vectors++; if (cur_idx !== 7'd0) begin errors++; $display("FAIL rest_cur_idx got %0d want 0", cur_idx); end
      end
    end
  endtask

  task automatic test_pause;
    int on_cnt = 0;
    clear_rom();
    rom_note[0] = 5'd3; rom_dur[0] = 4'd2;
    start = 1'b1;
    for (int k = 0; k <= 29; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
      if (note_out == 5'd3) on_cnt++;
      if (k >= 5 && k <= 14) begin
        vectors++; if (note_out !== 5'd0) begin errors++; $display("FAIL pause_mute k=%0d got %0d want 0", k, note_out); end
      end
      if (k == 15) begin
        vectors++; if (note_out !== 5'd3) begin errors++; $display("FAIL pause_resume got %0d want 3", note_out); end
      end
      if (k == 27) begin
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL pause_end done=%0b busy=%0b want 1/0", done, busy); end
      end
      if (k == 4) pause = 1'b1;
      if (k == 14) pause = 1'b0;
    end
    vectors++; if (on_cnt != 8) begin errors++; $display("FAIL pause_total got %0d cycles want 8", on_cnt); end
  endtask

  task automatic test_loop;
    int done_cnt = 0;
    clear_rom();
    for (int i = 0; i < DEPTH; i++) begin
      rom_note[i] = 5'd1;
      rom_dur[i]  = 4'd1;
    end
    loop_en = 1'b1;
    start = 1'b1;
    for (int k = 0; k <= 1005; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
      if (done) done_cnt++;
      if (k == 990) begin
        vectors++; if (mem_addr !== 7'd99 || mem_rd !== 1'b1) begin errors++; $display("FAIL loop_last_fetch addr=%0d rd=%0b want 99/1", mem_addr, mem_rd); end
      end
      if (k == 992) begin
        vectors++; if (note_out !== 5'd1 || cur_idx !== 7'd99) begin errors++; $display("FAIL loop_last_play note=%0d idx=%0d want 1/99", note_out, cur_idx); end
      end
      if (k == 1000) begin
        vectors++; if (busy !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL loop_end busy=%0b rd=%0b want 1/0", busy, mem_rd); end
      end
      if (k == 1001) begin
        vectors++; if (mem_addr !== 7'd0 || mem_rd !== 1'b1) begin errors++; $display("FAIL loop_wrap addr=%0d rd=%0b want 0/1", mem_addr, mem_rd); end
      end
      if (k == 1003) begin
        vectors++; if (cur_idx !== 7'd0 || note_out !== 5'd1) begin errors++; $display("FAIL loop_replay idx=%0d note=%0d want 0/1", cur_idx, note_out); end
      end
    end
    vectors++; if (done_cnt != 0) begin errors++; $display("FAIL loop_no_done got %0d pulses want 0", done_cnt); end
    loop_en = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop busy got %0b want 0", busy); end
  endtask

  task automatic test_stop;
    clear_rom();
    rom_note[0] = 5'd3; rom_dur[0] = 4'd2;
    rom_note[1] = 5'd5; rom_dur[1] = 4'd1;
    start = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
      if (k == 4) begin
        start = 1'b0;
        vectors++; if (mem_rd !== 1'b0 || note_out !== 5'd3) begin errors++; $display("FAIL stop_busy_start rd=%0b note=%0d want 0/3", mem_rd, note_out); end
      end
      if (k == 3) start = 1'b1;
    end
    vectors++; if (note_out !== 5'd5 || mem_addr !== 7'd1) begin errors++; $display("FAIL stop_pre note=%0d addr=%0d want 5/1", note_out, mem_addr); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %0b want 0", busy); end
    vectors++; if (note_out !== 5'd0) begin errors++; $display("FAIL stop_note got %0d want 0", note_out); end
    vectors++; if (mem_addr !== 7'd0) begin errors++; $display("FAIL stop_addr got %0d want 0", mem_addr); end
    vectors++; if (mem_rd !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stop_rd_done rd=%0b done=%0b want 0/0", mem_rd, done); end
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    vectors++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL start_stop busy=%0b rd=%0b want 0/0", busy, mem_rd); end
    cyc();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_after busy got %0b want 0", busy); end
  endtask

  task automatic test_enable;
    int on_cnt = 0;
    clear_rom();
    rom_note[0] = 5'd3; rom_dur[0] = 4'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    en = 1'b0;
    #1;
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL en_rd_gate got %0b want 0", mem_rd); end
    repeat (3) cyc();
    vectors++; if (busy !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL en_freeze_fetch busy=%0b rd=%0b want 1/0", busy, mem_rd); end
    en = 1'b1;
    #1;
    vectors++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL en_rd_resume got %0b want 1", mem_rd); end
    cyc();
    cyc();
    vectors++; if (note_out !== 5'd3) begin errors++; $display("FAIL en_play got %0d want 3", note_out); end
    en = 1'b0;
    repeat (6) cyc();
    vectors++; if (note_out !== 5'd3 || busy !== 1'b1) begin errors++; $display("FAIL en_freeze_play note=%0d busy=%0b want 3/1", note_out, busy); end
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (note_out == 5'd3) on_cnt++;
    end
    vectors++; if (on_cnt != 7) begin errors++; $display("FAIL en_play_len got %0d want 7", on_cnt); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_async_reset;
    clear_rom();
    rom_note[0] = 5'd3; rom_dur[0] = 4'd2;
    rom_note[1] = 5'd5; rom_dur[1] = 4'd1;
    start = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
    end
    vectors++; if (busy !== 1'b1 || cur_idx !== 7'd1 || note_out !== 5'd0) begin errors++; $display("FAIL arst_pre busy=%0b idx=%0d note=%0d want 1/1/0", busy, cur_idx, note_out); end
    #3;
    rst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %0b want 0", busy); end
    vectors++; if (mem_addr !== 7'd0 || cur_idx !== 7'd0) begin errors++; $display("FAIL arst_addr addr=%0d idx=%0d want 0/0", mem_addr, cur_idx); end
    vectors++; if (note_out !== 5'd0 || mem_rd !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_outs note=%0d rd=%0b done=%0b want 0", note_out, mem_rd, done); end
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_release done=%0b busy=%0b want 0/0", done, busy); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    vectors++; if (mem_addr !== 7'd0 || mem_rd !== 1'b1) begin errors++; $display("FAIL arst_restart addr=%0d rd=%0b want 0/1", mem_addr, mem_rd); end
    cyc();
    cyc();
    vectors++; if (note_out !== 5'd3 || cur_idx !== 7'd0) begin errors++; $display("FAIL arst_replay note=%0d idx=%0d want 3/0", note_out, cur_idx); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rest();
    test_pause();
    test_loop();
    test_stop();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
